csr_commit_ctrl: RTL



---
 rtl/csr_commit_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/csr_commit_ctrl.sv
// Commit-side CSR sequencer: one CSR op from ROB head to CSR file and back, strictly serialised.
// Latency: ack 2 cycles after request acceptance at best; no flow-through; request held until csr_req_ready_i.
module csr_commit_ctrl #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            commit_valid_i,
    input  logic [1:0]      commit_op_i,
    input  logic [XLEN-1:0] commit_wdata_i,
    input  logic [11:0]     csr_addr_i,
    output logic            commit_ack_o,
    output logic [XLEN-1:0] commit_rdata_o,
    output logic            commit_ex_o,
    output logic            csr_commit_o,
    output logic            flush_pipe_o,
    output logic            busy_o,
    output logic            csr_req_valid_o,
    input  logic            csr_req_ready_i,
    output logic [11:0]     csr_req_addr_o,
    output logic [1:0]      csr_req_op_o,
    output logic [XLEN-1:0] csr_req_wdata_o,
    input  logic            csr_rsp_valid_i,
    input  logic [XLEN-1:0] csr_rsp_rdata_i,
    input  logic            csr_rsp_ex_i
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [1:0]     OP_READ  = 2'd3;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [11:0]       addr_q;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              ex_q;
    logic              timeout_hit;
    logic              rsp_or_to;

    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);
    assign rsp_or_to   = csr_rsp_valid_i || timeout_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (commit_valid_i && !flush_i) state_d = REQ;
            REQ: begin
                if (flush_i)              state_d = IDLE;
                else if (csr_req_ready_i) state_d = WAIT;
            end
            // A flush that coincides with the response/timeout has nothing left to drain.
            WAIT: begin
                if (flush_i)        state_d = rsp_or_to ? IDLE : DRAIN;
                else if (rsp_or_to) state_d = DONE;
            end
            DONE:  state_d = IDLE;
            DRAIN: if (rsp_or_to) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ex_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && commit_valid_i && !flush_i) begin
                addr_q  <= csr_addr_i;
                op_q    <= commit_op_i;
                wdata_q <= commit_wdata_i;
            end
            if (state_q == REQ) begin
                cnt_q <= '0;
            end else if (state_q == WAIT || state_q == DRAIN) begin
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == WAIT && !flush_i) begin
                if (csr_rsp_valid_i) begin
                    rdata_q <= csr_rsp_rdata_i;
                    ex_q    <= csr_rsp_ex_i;
                end else if (timeout_hit) begin
                    rdata_q <= '0;
                    ex_q    <= 1'b1;
                end
            end
        end
    end

    assign commit_ack_o    = (state_q == DONE);
    assign csr_commit_o    = (state_q == DONE);
    assign commit_rdata_o  = commit_ack_o ? rdata_q : '0;
    assign commit_ex_o     = commit_ack_o & ex_q;
    assign flush_pipe_o    = commit_ack_o && (op_q != OP_READ) && !ex_q;
    assign busy_o          = (state_q != IDLE);
    assign csr_req_valid_o = (state_q == REQ);
    assign csr_req_addr_o  = addr_q;
    assign csr_req_op_o    = op_q;
    assign csr_req_wdata_o = wdata_q;

endmodule
